multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max consecutive cycles spent waiting for mem_ack before fault.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  3  IR[15:13]: ADD=0, ADDI=1, NAND=2, LUI=3, SW=4, LW=5, BEQ=6, JALR=7.
REQ-005 imm_nz  input  1  IR[6:0] != 0; used only with HALT_DETECT_EN.
REQ-006 alu_stat  input  1  ALU equality flag (ina == inb).
REQ-007 mem_ack  input  1  memory completion for the current request.
REQ-008 mem_req / mem_we / mem_addr_sel  output  1 each  request, write, address select (0=PC, 1=ALU out).
REQ-009 ir_we / pc_we / rf_we  output  1 each  IR, PC, register-file write enables.
REQ-010 pc_sel  output  2  0=PC+1, 1=PC+1+simm7, 2=regA (JALR).
REQ-011 rf_wsel  output  2  0=ALU out, 1=mem data, 2=PC+1, 3=imm10<<6.
REQ-012 alu_funct  output  `FUNCT_LEN  0=add, 1=nand; alu_bsel  output  1  0=regB, 1=simm7.
REQ-013 halted, err  output  1 each  terminal-state status flags.

Function
REQ-014 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT, ERR; outputs are a Moore/Mealy function of state, latched op_q and alu_stat; any output not listed is 0.
REQ-015 FETCH: mem_req=1, mem_addr_sel=0; on mem_ack assert ir_we same cycle, go DECODE; otherwise stay.
REQ-016 DECODE: one cycle; latch opcode into op_q; go EXEC; opcode input ignored elsewhere.
REQ-017 EXEC ADD/NAND: alu_bsel=0, alu_funct=0/1; ADDI: alu_bsel=1, funct=0; LUI: no ALU use; all four go WB.
REQ-018 EXEC SW/LW: funct=0, alu_bsel=1; go MEM.
REQ-019 EXEC BEQ: funct=0, alu_bsel=0, pc_we=1, pc_sel=alu_stat?1:0; go FETCH.
REQ-020 EXEC JALR: rf_we=1, rf_wsel=2, pc_we=1, pc_sel=2; go FETCH.
REQ-021 MEM: mem_req=1, mem_addr_sel=1, mem_we=(op_q==SW), funct=0, alu_bsel=1 held; on ack SW: pc_we=1, pc_sel=0, go FETCH; LW: go WB.
REQ-022 WB: rf_we=1, rf_wsel=1 for LW, 3 for LUI, else 0 with EXEC ALU controls held; pc_we=1, pc_sel=0; go FETCH.
REQ-023 Latency with zero-wait memory: BEQ/JALR 3 cycles, ADD/ADDI/NAND/LUI/SW 4, LW 5.
REQ-024 Wait counter: clears on entry to FETCH/MEM and on ack; increments each non-ack cycle in FETCH/MEM; at TIMEOUT go ERR.
REQ-025 mem_ack and counter reaching TIMEOUT in same cycle: ack wins.
REQ-026 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-027 HALT and ERR are absorbing: halted=1 or err=1, all enables 0, until rst.

Reset
REQ-028 rst high on any clock edge, including mid-MEM or in HALT/ERR: state=FETCH, op_q=0, counter=0.
REQ-029 During a rst cycle all outputs SHALL be 0; mem_req rises first cycle after rst deasserts.

Configuration
REQ-030 Macro HALT_DETECT_EN: defined -> EXEC JALR with imm_nz=1 goes HALT with no rf_we/pc_we; undefined -> imm_nz ignored, HALT unreachable, halted tied 0.

Verification
REQ-031 rst, then ADD with ack every request cycle -> ir_we cycle 1, rf_we+pc_we cycle 4, rf_wsel=0, funct=0, back in FETCH.
REQ-032 BEQ with alu_stat=1, then alu_stat=0 -> pc_we in cycle 3 with pc_sel=1, then pc_sel=0.
REQ-033 LW, mem_ack delayed 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0, rf_we with rf_wsel=1 one cycle after ack.
REQ-034 FETCH with no ack, TIMEOUT=15 -> err=1 after 15 wait cycles; ack arriving on cycle 15 -> no err.
REQ-035 JALR, imm_nz=1, HALT_DETECT_EN defined -> halted=1, no writes; undefined -> rf_wsel=2, pc_sel=2.
REQ-036 rst asserted during MEM of SW -> mem_req=0, mem_we=0 that cycle; FETCH restarts next cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-wait timeout to ERR.
// Build option: define HALT_DETECT_EN to make JALR with a nonzero imm7 enter an absorbing HALT state.
`ifndef FUNCT_LEN
`define FUNCT_LEN 1
`endif

module multicycle_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            opcode,
   input  logic                  imm_nz,
   input  logic                  alu_stat,
   input  logic                  mem_ack,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic                  mem_addr_sel,
   output logic                  ir_we,
   output logic                  pc_we,
   output logic                  rf_we,
   output logic [1:0]            pc_sel,
   output logic [1:0]            rf_wsel,
   output logic [`FUNCT_LEN-1:0] alu_funct,
   output logic                  alu_bsel,
   output logic                  halted,
   output logic                  err
);
   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_LUI  = 3'd3;
   localparam logic [2:0] OP_SW   = 3'd4;
   localparam logic [2:0] OP_LW   = 3'd5;
   localparam logic [2:0] OP_BEQ  = 3'd6;

   logic [2:0]    r_state;
   logic [2:0]    r_op;
   logic [CW-1:0] r_cnt;
   logic [2:0]    w_nxt;
   logic          w_tmo;

`ifndef HALT_DETECT_EN
   logic w_unused_imm;
   assign w_unused_imm = imm_nz;
`endif

   // This wait cycle would be the TIMEOUT-th consecutive one without an ack.
   assign w_tmo = (int'(r_cnt) + 1 >= TIMEOUT);

   always_comb begin
      w_nxt        = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      rf_we        = 1'b0;
      pc_sel       = 2'd0;
      rf_wsel      = 2'd0;
      alu_funct    = '0;
      alu_bsel     = 1'b0;
      halted       = 1'b0;
      err          = 1'b0;
      if (!rst) begin
         case (r_state)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  ir_we = 1'b1;
                  w_nxt = S_DECODE;
               end else if (w_tmo) begin
                  w_nxt = S_ERR;
               end
            end
            S_DECODE: w_nxt = S_EXEC;
            S_EXEC: begin
               case (r_op)
                  OP_ADD, OP_LUI: w_nxt = S_WB;
                  OP_ADDI: begin
                     alu_bsel = 1'b1;
                     w_nxt    = S_WB;
                  end
                  OP_NAND: begin
                     alu_funct = `FUNCT_LEN'(1);
                     w_nxt     = S_WB;
                  end
                  OP_SW, OP_LW: begin
                     alu_bsel = 1'b1;
                     w_nxt    = S_MEM;
                  end
                  OP_BEQ: begin
                     pc_we  = 1'b1;
                     pc_sel = {1'b0, alu_stat};
                     w_nxt  = S_FETCH;
                  end
                  default: begin
`ifdef HALT_DETECT_EN
                     if (imm_nz) begin
                        w_nxt = S_HALT;
                     end else begin
                        rf_we   = 1'b1;
                        rf_wsel = 2'd2;
                        pc_we   = 1'b1;
                        pc_sel  = 2'd2;
                        w_nxt   = S_FETCH;
                     end
`else
                     rf_we   = 1'b1;
                     rf_wsel = 2'd2;
                     pc_we   = 1'b1;
                     pc_sel  = 2'd2;
                     w_nxt   = S_FETCH;
`endif
                  end
               endcase
            end
            S_MEM: begin
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
               mem_we       = (r_op == OP_SW);
               alu_bsel     = 1'b1;
               if (mem_ack) begin
                  if (r_op == OP_SW) begin
                     pc_we = 1'b1;
                     w_nxt = S_FETCH;
                  end else begin
                     w_nxt = S_WB;
                  end
               end else if (w_tmo) begin
                  w_nxt = S_ERR;
               end
            end
            S_WB: begin
               rf_we = 1'b1;
               pc_we = 1'b1;
               w_nxt = S_FETCH;
               case (r_op)
                  OP_LW:   rf_wsel = 2'd1;
                  OP_LUI:  rf_wsel = 2'd3;
                  OP_ADDI: alu_bsel = 1'b1;
                  OP_NAND: alu_funct = `FUNCT_LEN'(1);
                  default: ;
               endcase
            end
            S_HALT: begin
`ifdef HALT_DETECT_EN
               halted = 1'b1;
`endif
            end
            S_ERR: err = 1'b1;
            default: w_nxt = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_op    <= 3'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt;
         if (r_state == S_DECODE) r_op <= opcode;
         // Counter only runs while still waiting in FETCH/MEM; any exit or ack clears it.
         if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ack && w_nxt == r_state)
            r_cnt <= r_cnt + 1'b1;
         else
            r_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-level check of multicycle_ctrl against an expected per-cycle trace model.
`ifndef FUNCT_LEN
`define FUNCT_LEN 1
`endif

module tb_multicycle_ctrl;
   localparam int TO = 15;
   localparam logic [2:0] ADD = 0, ADDI = 1, NAND = 2, LUI = 3, SW = 4, LW = 5, BEQ = 6, JALR = 7;
   localparam logic [13:0] MREQ = 14'h2000, MWE = 14'h1000, MADR = 14'h0800, IRWE = 14'h0400,
                           PCWE = 14'h0200, RFWE = 14'h0100, PS1 = 14'h0040, PS2 = 14'h0080,
                           RS1 = 14'h0010, RS2 = 14'h0020, RS3 = 14'h0030, FN = 14'h0008,
                           BS = 14'h0004, HLT = 14'h0002, ERRB = 14'h0001;

   logic clk = 1'b0, rst = 1'b1;
   logic [2:0] opcode = 3'd0;
   logic imm_nz = 1'b0, alu_stat = 1'b0, mem_ack = 1'b0;
   logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, alu_bsel, halted, err;
   logic [1:0] pc_sel, rf_wsel;
   logic [`FUNCT_LEN-1:0] alu_funct;
   logic [13:0] outv;
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .imm_nz(imm_nz), .alu_stat(alu_stat),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .pc_sel(pc_sel), .rf_wsel(rf_wsel),
      .alu_funct(alu_funct), .alu_bsel(alu_bsel), .halted(halted), .err(err)
   );

   assign outv = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, pc_sel, rf_wsel,
                  alu_funct[0], alu_bsel, halted, err};

   task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] rop();
      return 3'($urandom_range(0, 7));
   endfunction
   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit halts(input logic [2:0] op, input logic imm);
`ifdef HALT_DETECT_EN
      return (op == JALR) && imm;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [13:0] exec_vec(input logic [2:0] op, input logic stat, input logic imm);
      case (op)
         ADDI, SW, LW: return BS;
         NAND:         return FN;
         BEQ:          return PCWE | (stat ? PS1 : 14'h0);
         JALR:         return halts(op, imm) ? 14'h0 : (RFWE | PCWE | RS2 | PS2);
         default:      return 14'h0;
      endcase
   endfunction

   function automatic logic [13:0] wb_vec(input logic [2:0] op);
      case (op)
         LW:      return RFWE | PCWE | RS1;
         LUI:     return RFWE | PCWE | RS3;
         ADDI:    return RFWE | PCWE | BS;
         NAND:    return RFWE | PCWE | FN;
         default: return RFWE | PCWE;
      endcase
   endfunction

   task automatic step(input logic ack, input logic [2:0] op, input logic [13:0] exp, input string tag);
      @(negedge clk);
      mem_ack = ack;
      opcode  = op;
      #1 chk(tag, outv, exp);
   endtask

   task automatic do_reset(input logic ack);
      @(negedge clk);
      rst = 1'b1;
      mem_ack = ack;
      opcode = rop();
      alu_stat = rb();
      #1 chk("rst_outputs_zero", outv, 14'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      mem_ack = 1'b0;
   endtask

   // A request waits w cycles then acks; w >= TO means it never acks in time.
   task automatic wait_req(input int w, input logic [13:0] base, input logic [13:0] extra,
                           input string tag, output bit ok);
      for (int i = 0; i < w && i < TO; i++) step(1'b0, rop(), base, {tag, "_wait"});
      if (w >= TO) begin
         step(rb(), rop(), ERRB, "timeout_err");
         step(rb(), rop(), ERRB, "err_hold");
         do_reset(rb());
         ok = 1'b0;
      end else begin
         step(1'b1, rop(), base | extra, {tag, "_ack"});
         ok = 1'b1;
      end
   endtask

   task automatic run_instr(input logic [2:0] op, input logic stat, input logic imm,
                            input int fw, input int mw);
      bit ok;
      alu_stat = stat;
      imm_nz   = imm;
      wait_req(fw, MREQ, IRWE, "fetch", ok);
      if (!ok) return;
      step(rb(), op, 14'h0, "decode");
      step(rb(), rop(), exec_vec(op, stat, imm), "exec");
      if (halts(op, imm)) begin
         step(rb(), rop(), HLT, "halted");
         step(rb(), rop(), HLT, "halt_hold");
         do_reset(rb());
         return;
      end
      if (op == SW || op == LW) begin
         wait_req(mw, MREQ | MADR | BS | ((op == SW) ? MWE : 14'h0),
                  (op == SW) ? PCWE : 14'h0, "mem", ok);
         if (!ok || op == SW) return;
      end
      if (op != BEQ && op != JALR) step(rb(), rop(), wb_vec(op), "wb");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      do_reset(1'b1);
      run_instr(ADD, 1'b0, 1'b0, 0, 0);
      run_instr(BEQ, 1'b1, 1'b0, 0, 0);
      run_instr(BEQ, 1'b0, 1'b0, 0, 0);
      run_instr(LW, 1'b0, 1'b0, 0, 3);
      run_instr(ADD, 1'b0, 1'b0, TO - 1, 0);
      run_instr(ADD, 1'b0, 1'b0, TO, 0);
      run_instr(SW, 1'b0, 1'b0, 1, TO);
      run_instr(JALR, 1'b0, 1'b1, 0, 0);
      run_instr(JALR, 1'b1, 1'b0, 0, 0);
      // Reset in the middle of a store's memory phase
      alu_stat = 1'b0;
      step(1'b1, rop(), MREQ | IRWE, "sw_fetch");
      step(rb(), SW, 14'h0, "sw_decode");
      step(rb(), rop(), BS, "sw_exec");
      step(1'b0, rop(), MREQ | MADR | BS | MWE, "sw_mem_wait");
      do_reset(1'b1);
      run_instr(ADD, 1'b0, 1'b0, 0, 0);
      for (int k = 0; k < 80; k++) begin
         int fw, mw;
         fw = ($urandom_range(0, 15) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 3);
         mw = ($urandom_range(0, 15) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 3);
         run_instr(rop(), rb(), rb(), fw, mw);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
